// File: rtl/instr_imm_packer_if.sv
// Field-in / packed-word-out bundle for instr_imm_packer; the packer takes the slave side.
interface instr_imm_packer_if #(
    parameter int CNT_W = 16
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [6:0]       opcode_i;
    logic [4:0]       rd_i;
    logic [2:0]       funct3_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [31:0]      imm_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      instr_o;
    logic             err_o;
    logic [1:0]       err_code_o;
    logic [CNT_W-1:0] enc_count_o;

    modport master (
        output in_valid_i, opcode_i, rd_i, funct3_i, rs1_i, rs2_i, imm_i, out_ready_i,
        input  in_ready_o, out_valid_o, instr_o, err_o, err_code_o, enc_count_o
    );

    modport slave (
        input  in_valid_i, opcode_i, rd_i, funct3_i, rs1_i, rs2_i, imm_i, out_ready_i,
        output in_ready_o, out_valid_o, instr_o, err_o, err_code_o, enc_count_o
    );
endinterface

// File: rtl/instr_imm_packer.sv
// Packs RV32I I/S/B fields plus a signed immediate into instruction words queued in a small FIFO.
// Define IMM_RANGE_CHECK_EN to reject out-of-range immediates and odd B offsets.
module instr_imm_packer #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input logic               clk_i,
    input logic               rst_i,
    instr_imm_packer_if.slave bus
);
    localparam int             PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_OPCODE = 2'b01,
        ERR_RANGE  = 2'b10,
        ERR_ALIGN  = 2'b11
    } err_e;

    typedef enum logic [1:0] {
        CLS_BAD,
        CLS_I,
        CLS_S,
        CLS_B
    } cls_e;

    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             errPulse_q;
    err_e             errCode_q;
    logic [CNT_W-1:0] encCount_q;

    cls_e        cls;
    err_e        errCode;
    logic [31:0] packedWord;
    logic        full;
    logic        empty;
    logic        accept;
    logic        pushOk;
    logic        pop;

    always_comb begin
        cls = CLS_BAD;
        case (bus.opcode_i)
            7'b0010011, 7'b0000011: cls = CLS_I;
            7'b0100011:             cls = CLS_S;
            7'b1100011:             cls = CLS_B;
            default:                cls = CLS_BAD;
        endcase
    end

    // Fields common to all three formats are placed first; format-specific bits overlay them.
    always_comb begin
        packedWord = {12'd0, bus.rs1_i, bus.funct3_i, 5'd0, bus.opcode_i};
        case (cls)
            CLS_I: begin
                packedWord[31:20] = bus.imm_i[11:0];
                packedWord[11:7]  = bus.rd_i;
            end
            CLS_S: begin
                packedWord[31:25] = bus.imm_i[11:5];
                packedWord[24:20] = bus.rs2_i;
                packedWord[11:7]  = bus.imm_i[4:0];
            end
            CLS_B: begin
                packedWord[31]    = bus.imm_i[12];
                packedWord[30:25] = bus.imm_i[10:5];
                packedWord[24:20] = bus.rs2_i;
                packedWord[11:8]  = bus.imm_i[4:1];
                packedWord[7]     = bus.imm_i[11];
            end
            default: ;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    logic signed [31:0] immS;
    logic               immFitsIS;
    logic               immFitsB;

    assign immS      = bus.imm_i;
    assign immFitsIS = (immS >= -32'sd2048) && (immS <= 32'sd2047);
    assign immFitsB  = (immS >= -32'sd4096) && (immS <= 32'sd4094);

    always_comb begin
        errCode = ERR_NONE;
        if (cls == CLS_BAD) begin
            errCode = ERR_OPCODE;
        end else if (cls == CLS_B) begin
            if (!immFitsB) begin
                errCode = ERR_RANGE;
            end else if (bus.imm_i[0]) begin
                errCode = ERR_ALIGN;
            end
        end else if (!immFitsIS) begin
            errCode = ERR_RANGE;
        end
    end
`else
    // Upper immediate bits are simply truncated away when checks are disabled.
    logic [18:0] unusedImmHigh;

    assign unusedImmHigh = bus.imm_i[31:13];

    always_comb begin
        errCode = ERR_NONE;
        if (cls == CLS_BAD) begin
            errCode = ERR_OPCODE;
        end
    end
`endif

    assign full   = (count_q == FULL_CNT);
    assign empty  = (count_q == '0);
    assign accept = bus.in_valid_i && !full;
    assign pushOk = accept && (errCode == ERR_NONE);
    assign pop    = !empty && bus.out_ready_i;

    always_comb begin
        count_d = count_q;
        if (pushOk && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (!pushOk && pop) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            errPulse_q <= 1'b0;
            errCode_q  <= ERR_NONE;
            encCount_q <= '0;
        end else begin
            count_q    <= count_d;
            errPulse_q <= accept && (errCode != ERR_NONE);
            if (accept && (errCode != ERR_NONE)) begin
                errCode_q <= errCode;
            end
            if (pushOk) begin
                wrPtr_q    <= wrPtr_q + PTR_W'(1);
                encCount_q <= encCount_q + CNT_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= packedWord;
        end
    end

    assign bus.in_ready_o  = !full;
    assign bus.out_valid_o = !empty;
    assign bus.instr_o     = empty ? 32'd0 : mem_q[rdPtr_q];
    assign bus.err_o       = errPulse_q;
    assign bus.err_code_o  = errCode_q;
    assign bus.enc_count_o = encCount_q;
endmodule

// File: tb/tb_instr_imm_packer.sv
// Scoreboard bench for instr_imm_packer: a behavioural encoder model feeds expected words
// and error codes into queues that a negedge monitor drains as the DUT presents them.
module tb_instr_imm_packer;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 16;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;

    always #5 clk_i = ~clk_i;

    instr_imm_packer_if #(.CNT_W(CNT_W)) bus ();

    instr_imm_packer #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    int          testsRun    = 0;
    int          testsFailed = 0;
    logic [31:0] expQ[$];
    logic [1:0]  errQ[$];
    int unsigned modelCount  = 0;
    bit          randReady   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Encoder reference: classify the opcode, apply the range rules on the integer value,
    // then build the word by placing each field with arithmetic on the unsigned immediate.
    function automatic void refModel(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                     input logic [4:0] rs1, input logic [4:0] rs2, input int imm,
                                     output logic [31:0] word, output logic [1:0] code);
        int          kind;
        int unsigned ui;
        int unsigned off;
        word = 32'd0;
        code = 2'd0;
        ui   = imm;
        if (op == 7'b0010011 || op == 7'b0000011) kind = 1;
        else if (op == 7'b0100011)                kind = 2;
        else if (op == 7'b1100011)                kind = 3;
        else                                      kind = 0;
        if (kind == 0) begin
            code = 2'd1;
            return;
        end
`ifdef IMM_RANGE_CHECK_EN
        if (kind == 3) begin
            if (imm < -4096 || imm > 4094) code = 2'd2;
            else if ((imm & 1) != 0)       code = 2'd3;
        end else if (imm < -2048 || imm > 2047) begin
            code = 2'd2;
        end
        if (code != 2'd0) return;
`endif
        word = 32'(op) + (32'(f3) << 12) + (32'(rs1) << 15);
        if (kind == 1) begin
            word = word + ((ui % 4096) << 20) + (32'(rd) << 7);
        end else if (kind == 2) begin
            word = word + (((ui % 4096) / 32) << 25) + (32'(rs2) << 20) + ((ui % 32) << 7);
        end else begin
            off  = ui % 8192;
            word = word + ((off / 4096) << 31) + (((off / 32) % 64) << 25) + (32'(rs2) << 20)
                        + (((off / 2) % 16) << 8) + (((off / 2048) % 2) << 7);
        end
    endfunction

    task automatic applyStimulus(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3,
                                 input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        logic [31:0] w;
        logic [1:0]  c;
        int          waitCycles = 0;
        bit          done = 0;
        bus.opcode_i   = op;
        bus.rd_i       = rd;
        bus.funct3_i   = f3;
        bus.rs1_i      = rs1;
        bus.rs2_i      = rs2;
        bus.imm_i      = imm;
        bus.in_valid_i = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            if (bus.in_ready_o) begin
                @(posedge clk_i);
                refModel(op, rd, f3, rs1, rs2, imm, w, c);
                if (c == 2'd0) begin
                    expQ.push_back(w);
                    modelCount++;
                end else begin
                    errQ.push_back(c);
                end
                done = 1;
            end else begin
                waitCycles++;
                if (waitCycles > 100) begin
                    checkOutput("acceptTimeout", 32'(bus.in_ready_o), 32'd1);
                    done = 1;
                end else begin
                    @(posedge clk_i);
                end
            end
        end
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic drainFifo();
        int cycles = 0;
        bus.out_ready_i = 1'b1;
        while (bus.out_valid_o && cycles < 50) begin
            @(posedge clk_i);
            #1;
            cycles++;
        end
        checkOutput("drainOutValid", 32'(bus.out_valid_o), 32'd0);
        bus.out_ready_i = 1'b0;
    endtask

    task automatic popOne();
        bus.out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        bus.out_ready_i = 1'b0;
    endtask

    // Monitor: compares every word and error pulse the DUT presents against the queues.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                if (bus.out_valid_o && bus.out_ready_i) begin
                    if (expQ.size() == 0) checkOutput("unexpectedWord", 32'(bus.out_valid_o), 32'd0);
                    else                  checkOutput("instrWord", bus.instr_o, expQ.pop_front());
                end
                if (!bus.out_valid_o) checkOutput("instrWhenEmpty", bus.instr_o, 32'd0);
                if (bus.err_o) begin
                    if (errQ.size() == 0) checkOutput("unexpectedErr", 32'(bus.err_o), 32'd0);
                    else                  checkOutput("errCode", 32'(bus.err_code_o), 32'(errQ.pop_front()));
                end
                checkOutput("encCount", 32'(bus.enc_count_o), 32'(CNT_W'(modelCount)));
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (randReady) bus.out_ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int edges[13] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 3, -3, 0, 1};
        logic [6:0]  op;
        logic [31:0] imm;
        int          cycles;

        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.opcode_i    = '0;
        bus.rd_i        = '0;
        bus.funct3_i    = '0;
        bus.rs1_i       = '0;
        bus.rs2_i       = '0;
        bus.imm_i       = '0;

        #2;
        checkOutput("rstInReady", 32'(bus.in_ready_o), 32'd1);
        checkOutput("rstOutValid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("rstInstr", bus.instr_o, 32'd0);
        checkOutput("rstErr", 32'(bus.err_o), 32'd0);
        checkOutput("rstErrCode", 32'(bus.err_code_o), 32'd0);
        checkOutput("rstEncCount", 32'(bus.enc_count_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        applyStimulus(7'b0010011, 5'd5, 3'd0, 5'd6, 5'd0, -32'sd1);
        checkOutput("iValid", 32'(bus.out_valid_o), 32'd1);
        checkOutput("iWord", bus.instr_o, 32'hFFF30293);
        checkOutput("iCount", 32'(bus.enc_count_o), 32'd1);
        popOne();

        applyStimulus(7'b0100011, 5'd0, 3'd2, 5'd2, 5'd8, 32'd12);
        checkOutput("sWord", bus.instr_o, 32'h00812623);
        popOne();

        applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, -32'sd8);
        checkOutput("bWord", bus.instr_o, 32'hFE208CE3);
        popOne();

        applyStimulus(7'b0110011, 5'd1, 3'd0, 5'd1, 5'd1, 32'd0);
        checkOutput("badOpErr", 32'(bus.err_o), 32'd1);
        checkOutput("badOpCode", 32'(bus.err_code_o), 32'd1);
        checkOutput("badOpNoPush", 32'(bus.out_valid_o), 32'd0);
        checkOutput("badOpCount", 32'(bus.enc_count_o), 32'd3);
        @(posedge clk_i);
        #1;
        checkOutput("errPulseOnce", 32'(bus.err_o), 32'd0);
        checkOutput("errCodeHeld", 32'(bus.err_code_o), 32'd1);

`ifdef IMM_RANGE_CHECK_EN
        applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048);
        checkOutput("rangeCode", 32'(bus.err_code_o), 32'd2);
        checkOutput("rangeNoPush", 32'(bus.out_valid_o), 32'd0);
        applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3);
        checkOutput("alignCode", 32'(bus.err_code_o), 32'd3);
        checkOutput("alignNoPush", 32'(bus.out_valid_o), 32'd0);
`else
        applyStimulus(7'b0010011, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048);
        checkOutput("truncIWord", bus.instr_o, 32'h80000093);
        checkOutput("truncINoErr", 32'(bus.err_o), 32'd0);
        popOne();
        applyStimulus(7'b1100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3);
        checkOutput("truncBWord", bus.instr_o, 32'h00208163);
        popOne();
`endif

        // Fill to capacity with the consumer stalled, then release it.
        bus.out_ready_i = 1'b0;
        applyStimulus(7'b0000011, 5'd3, 3'd2, 5'd4, 5'd0, 32'd100);
        applyStimulus(7'b0100011, 5'd0, 3'd1, 5'd7, 5'd9, -32'sd100);
        checkOutput("fullInReady", 32'(bus.in_ready_o), 32'd0);
        fork
            applyStimulus(7'b1100011, 5'd0, 3'd5, 5'd10, 5'd11, 32'd64);
            begin
                repeat (3) @(posedge clk_i);
                #1;
                checkOutput("fullHeld", 32'(bus.in_ready_o), 32'd0);
                bus.out_ready_i = 1'b1;
            end
        join
        drainFifo();
        checkOutput("readyRestored", 32'(bus.in_ready_o), 32'd1);

        randReady = 1;
        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 5))
                0:       op = 7'b0010011;
                1:       op = 7'b0000011;
                2:       op = 7'b0100011;
                3, 4:    op = 7'b1100011;
                default: op = 7'($urandom);
            endcase
            case ($urandom_range(0, 3))
                0:       imm = 32'(edges[$urandom_range(0, 12)]);
                1:       imm = $urandom;
                default: imm = 32'($signed(13'($urandom)));
            endcase
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk_i);
                #1;
            end
            applyStimulus(op, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), imm);
        end
        randReady = 0;
        @(posedge clk_i);
        #1;
        drainFifo();
        repeat (2) @(posedge clk_i);
        #1;
        checkOutput("wordQueueEmpty", 32'(expQ.size()), 32'd0);
        checkOutput("errQueueEmpty", 32'(errQ.size()), 32'd0);

        // Reset while two words are queued must clear everything without a clock edge.
        applyStimulus(7'b0010011, 5'd2, 3'd0, 5'd3, 5'd0, 32'd7);
        applyStimulus(7'b0010011, 5'd4, 3'd0, 5'd5, 5'd0, 32'd9);
        checkOutput("preRstFull", 32'(bus.in_ready_o), 32'd0);
        @(posedge clk_i);
        #3;
        rst_i = 1'b0;
        expQ.delete();
        errQ.delete();
        modelCount = 0;
        #1;
        checkOutput("asyncOutValid", 32'(bus.out_valid_o), 32'd0);
        checkOutput("asyncInstr", bus.instr_o, 32'd0);
        checkOutput("asyncEncCount", 32'(bus.enc_count_o), 32'd0);
        checkOutput("asyncInReady", 32'(bus.in_ready_o), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        applyStimulus(7'b0100011, 5'd0, 3'd0, 5'd1, 5'd2, 32'd4);
        checkOutput("postRstCount", 32'(bus.enc_count_o), 32'd1);
        drainFifo();

        cycles = 0;
        while (expQ.size() != 0 && cycles < 20) begin
            @(posedge clk_i);
            cycles++;
        end
        checkOutput("finalQueueEmpty", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule

// File: doc/instr_imm_packer.md
Name: instr_imm_packer

Overview:
- Inverse of the immediate sign-extend path: accepts decoded instruction fields plus a 32-bit signed immediate, and packs them into a 32-bit RV32I I/S/B-format instruction word.
- Validates the opcode and immediate, then queues packed words in a small output FIFO with valid/ready handshakes on both sides.
- Sits in the test and instruction-memory preload path that feeds the CPU's instruction memory.

Parameters:
- FIFO_DEPTH, 2, output FIFO entries; power of two, ≥2.
- CNT_W, 16, width of encoded-instruction counter.

Ports:
- clk_i  input  1  clock; all logic rising-edge.
- rst_i  input  1  asynchronous, active-low reset.
- in_valid_i  input  1  input fields valid.
- in_ready_o  output  1  block can accept fields.
- opcode_i  input  7  instruction opcode.
- rd_i  input  5  destination register (I only).
- funct3_i  input  3  funct3 field.
- rs1_i  input  5  source register 1.
- rs2_i  input  5  source register 2 (S/B only).
- imm_i  input  32  two's-complement immediate.
- out_valid_o  output  1  instr_o holds a valid packed word.
- out_ready_i  input  1  consumer takes instr_o.
- instr_o  output  32  packed instruction at FIFO head.
- err_o  output  1  one-cycle error pulse.
- err_code_o  output  2  cause of last error.
- enc_count_o  output  CNT_W  successful encodes, wraps.

Behaviour:
- Reset (rst_i low, async): FIFO emptied, in_ready_o=1, out_valid_o=0, instr_o=0, err_o=0, err_code_o=0, enc_count_o=0. Assertion mid-transfer discards all queued and in-flight words.
- Handshakes:
  - Accept when in_valid_i && in_ready_o at a rising edge.
  - Pop when out_valid_o && out_ready_i.
  - in_ready_o = !full; registered state only, no same-cycle bypass of a pop.
  - out_valid_o = !empty.
- Latency: a valid word accepted at edge N appears on instr_o with out_valid_o=1 after edge N.
- instr_o: combinationally shows the head entry; 0 when empty.
- Opcode classes:
  - I: 0010011, 0000011.
  - S: 0100011.
  - B: 1100011.
  - Any other opcode is an error.
- Packing (bit positions of packed word; bits [14:12]=funct3_i, [19:15]=rs1_i, [6:0]=opcode_i):
  - I: [31:20]=imm[11:0], [11:7]=rd_i; rs2_i ignored.
  - S: [31:25]=imm[11:5], [24:20]=rs2_i, [11:7]=imm[4:0]; rd_i ignored.
  - B: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2_i, [11:8]=imm[4:1], [7]=imm[11]; rd_i ignored.
- Validity checks:
  - I/S range: -2048..2047.
  - B range: -4096..4094, and imm[0] must be 0.
- Error handling (on an accepted transaction):
  - Word is not pushed; enc_count_o unchanged.
  - err_o=1 for exactly one cycle after the accepting edge.
  - err_code_o is updated and held until the next error.
  - Codes: 01 bad opcode, 10 immediate out of range, 11 misaligned B offset.
  - Priority: 01 > 10 > 11.
- Counter: enc_count_o increments by 1 on each successful push; wraps from all-ones to 0.
- Simultaneous push and pop (not full, not empty): occupancy unchanged, order preserved.
- Full: in_ready_o=0; in_valid_i is ignored and fields must be held by the source.
- Empty with out_ready_i high: no pop, no state change.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: IMM_RANGE_CHECK_EN.
- Defined: range and alignment checks active, error codes 10/11 produced as above.
- Undefined:
  - No range or alignment checks; the immediate is silently truncated to the field bits, and B-type imm[0] is dropped.
  - Only error code 01 can occur.

Test Plan:
- Encode I, opcode 0010011, rd=5, funct3=0, rs1=6, imm=-1 → instr_o=32'hFFF30293 one cycle later, enc_count_o=1.
- Encode S, opcode 0100011, funct3=2, rs1=2, rs2=8, imm=12 → instr_o=32'h00812623.
- Encode B, opcode 1100011, funct3=0, rs1=1, rs2=2, imm=-8 → instr_o=32'hFE208CE3.
- Hold out_ready_i=0 and push 3 valid words with FIFO_DEPTH=2 → in_ready_o=0 after the 2nd accept. Then release → words pop in order and in_ready_o returns to 1.
- Bad inputs, each as one accepted transaction:
  - opcode 0110011 → err_o pulse, err_code_o=01, FIFO unchanged.
  - I-type imm=2048 with IMM_RANGE_CHECK_EN → err_code_o=10.
  - B-type imm=3 with IMM_RANGE_CHECK_EN → err_code_o=11.
- Assert rst_i low while the FIFO holds 2 words → out_valid_o=0, instr_o=0, enc_count_o=0 immediately, without waiting for a clock edge.
